// File: rtl/spi_cntrl_if.sv
// ---------------------------------------------------------------------------
// spi_cntrl_if
//
// User-side handshake bundle for spi_cntrl.
//
//   start          request a byte transfer (honoured only while busy=0)
//   data_to_send   byte to transmit, MSB first, sampled with start
//   hold_cs        sampled with start; 1 keeps SPI_CS low after the byte
//   data_received  last received byte, MSB first
//   busy           transfer in progress, start is ignored
//   done           one-cycle pulse coincident with a data_received update
//
// Modports:
//   master - user logic issuing transfers
//   slave  - the SPI controller
// ---------------------------------------------------------------------------
interface spi_cntrl_if;
    logic       start;
    logic [7:0] data_to_send;
    logic       hold_cs;
    logic [7:0] data_received;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output data_to_send,
        output hold_cs,
        input  data_received,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data_to_send,
        input  hold_cs,
        output data_received,
        output busy,
        output done
    );
endinterface

// File: rtl/spi_cntrl.sv
// ---------------------------------------------------------------------------
// spi_cntrl
//
// SPI main-side controller, mode 0 (CPOL=0, CPHA=0), one subunit.
// Transfers one byte per start request; hold_cs=1 keeps SPI_CS asserted
// afterwards so that multi-byte transactions can be chained.
//
// Parameters:
//   CLK_FREQUENCY   system clock frequency in Hz
//   SCLK_FREQUENCY  SPI_SCLK frequency in Hz
//   HALF = CLK_FREQUENCY/(2*SCLK_FREQUENCY) clock cycles per SCLK phase,
//   must be at least 3.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   user      spi_cntrl_if.slave: start/data_to_send/hold_cs in,
//             data_received/busy/done out
//   SPI_SCLK  serial clock, idle low
//   SPI_MOSI  serial data out
//   SPI_MISO  serial data in
//   SPI_CS    chip select, active low
//
// Build option:
//   SPI_CNTRL_MISO_SYNC_EN  when defined, SPI_MISO passes through a
//                           2-flop synchronizer before it is sampled.
//                           Output cycle timing is unchanged.
//
// All SPI-side outputs are registered and computed from the next state,
// so every pin changes exactly on the edge where the FSM changes phase.
// ---------------------------------------------------------------------------
module spi_cntrl #(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_cntrl_if.slave  user,
    output logic        SPI_SCLK,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    output logic        SPI_CS
);

    localparam int HALF  = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
    localparam int CNT_W = (HALF > 2) ? $clog2(HALF) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    generate
        if (HALF < 3) begin : g_half_check
            $fatal(1, "spi_cntrl: HALF=%0d, at least 3 clock cycles per SCLK phase required", HALF);
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        CS_HOLD,
        HOLD,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;       // cycles spent in the current phase
    logic [2:0]       bit_q, bit_d;       // bit index within the byte
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             hold_q, hold_d;
    logic [7:0]       data_received_q, data_received_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_q, cs_d;
    logic             miso_s;

    // -----------------------------------------------------------------------
    // MISO input path
    // -----------------------------------------------------------------------
`ifdef SPI_CNTRL_MISO_SYNC_EN
    // MISO is stable for the whole preceding low phase (HALF >= 3 cycles),
    // so two cycles of synchronizer latency still land inside it.
    logic [1:0] miso_sync_q, miso_sync_d;

    always_comb begin
        miso_sync_d = {miso_sync_q[0], SPI_MISO};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_sync_q <= 2'b00;
        end else begin
            miso_sync_q <= miso_sync_d;
        end
    end

    assign miso_s = miso_sync_q[1];
`else
    assign miso_s = SPI_MISO;
`endif

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_d           = bit_q;
        tx_d            = tx_q;
        rx_d            = rx_q;
        hold_d          = hold_q;
        data_received_d = data_received_q;
        done_d          = 1'b0;

        unique case (state_q)
            IDLE, HOLD: begin
                if (user.start) begin
                    tx_d    = user.data_to_send;
                    hold_d  = user.hold_cs;
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = LOW;
                end
            end

            LOW: begin
                if (cnt_q == CNT_LAST) begin
                    // The edge entering HIGH is the SCLK rising edge:
                    // capture the bit the subunit has held through LOW.
                    cnt_d   = '0;
                    rx_d    = {rx_q[6:0], miso_s};
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HIGH: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = CS_HOLD;
                    end else begin
                        tx_d    = {tx_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        state_d = LOW;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CS_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d           = '0;
                    done_d          = 1'b1;
                    data_received_d = rx_q;
                    state_d         = hold_q ? HOLD : GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Pin values for the phase being entered.
        cs_d   = !((state_d == LOW) || (state_d == HIGH) ||
                   (state_d == CS_HOLD) || (state_d == HOLD));
        sclk_d = (state_d == HIGH);
        mosi_d = ((state_d == LOW) || (state_d == HIGH)) ? tx_d[7] : 1'b0;
        busy_d = (state_d == LOW) || (state_d == HIGH) ||
                 (state_d == CS_HOLD) || (state_d == GAP);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_q           <= 3'd0;
            tx_q            <= 8'h00;
            rx_q            <= 8'h00;
            hold_q          <= 1'b0;
            data_received_q <= 8'h00;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            sclk_q          <= 1'b0;
            mosi_q          <= 1'b0;
            cs_q            <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_q           <= bit_d;
            tx_q            <= tx_d;
            rx_q            <= rx_d;
            hold_q          <= hold_d;
            data_received_q <= data_received_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            sclk_q          <= sclk_d;
            mosi_q          <= mosi_d;
            cs_q            <= cs_d;
        end
    end

    assign SPI_SCLK           = sclk_q;
    assign SPI_MOSI           = mosi_q;
    assign SPI_CS             = cs_q;
    assign user.data_received = data_received_q;
    assign user.busy          = busy_q;
    assign user.done          = done_q;

endmodule

// File: tb/tb_spi_cntrl.sv
// ---------------------------------------------------------------------------
// tb_spi_cntrl
//
// Directed bench for spi_cntrl at CLK=100 MHz, SCLK=10 MHz (HALF=5) with a
// behavioural mode-0 subunit. Cycle numbering: cycle 0 ends at the
// start-accept edge; values seen after edge n belong to cycle n+1.
// ---------------------------------------------------------------------------
module tb_spi_cntrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_sclk, spi_mosi, spi_cs;
    logic spi_miso = 1'b0;

    always #5 clk = ~clk;

    spi_cntrl_if u_if ();

    spi_cntrl #(
        .CLK_FREQUENCY (100_000_000),
        .SCLK_FREQUENCY(10_000_000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .user    (u_if),
        .SPI_SCLK(spi_sclk),
        .SPI_MOSI(spi_mosi),
        .SPI_MISO(spi_miso),
        .SPI_CS  (spi_cs)
    );

    // ---------------- mode-0 subunit model ----------------
    logic [7:0] sub_byte = 8'h00;
    logic [7:0] sub_sh = 8'h00;
    logic [7:0] sub_rx = 8'h00;
    int         sub_bits = 0;
    logic [7:0] sub_q[$];
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;

    always @(spi_cs, spi_sclk) begin
        if (prev_cs && !spi_cs) begin
            sub_bits = 0;
            sub_sh   = sub_byte;
        end else if (!spi_cs && !prev_sclk && spi_sclk) begin
            sub_rx = {sub_rx[6:0], spi_mosi};
            sub_bits++;
            if (sub_bits == 8) begin
                sub_q.push_back(sub_rx);
                sub_bits = 0;
            end
        end else if (!spi_cs && prev_sclk && !spi_sclk) begin
            if (sub_bits == 0) sub_sh = sub_byte;
            else               sub_sh = {sub_sh[6:0], 1'b0};
        end
        spi_miso  = spi_cs ? 1'b0 : sub_sh[7];
        prev_cs   = spi_cs;
        prev_sclk = spi_sclk;
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // observations of one transfer
    int         o_done_cnt, o_done_cyc, o_rises, o_first_rise, o_last_fall;
    int         o_cs_first_low, o_cs_last_low, o_cs_high_gap;
    logic [7:0] o_rx;
    logic       o_cs_at_done, o_busy_at_done, o_busy1, o_busy90, o_busy91;

    task automatic xfer(input logic [7:0] d, input logic h, input int ncyc,
                        input bit stop_at_done, input int inj_cyc);
        logic prev_s;
        o_done_cnt = 0; o_done_cyc = -1; o_rises = 0; o_first_rise = -1;
        o_last_fall = -1; o_cs_first_low = -1; o_cs_last_low = -1;
        o_cs_high_gap = 0; o_rx = 8'h00; o_cs_at_done = 1'bx;
        o_busy_at_done = 1'bx; o_busy1 = 1'b0; o_busy90 = 1'b0; o_busy91 = 1'b1;
        prev_s = spi_sclk;
        u_if.data_to_send = d;
        u_if.hold_cs      = h;
        u_if.start        = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == inj_cyc) begin
                u_if.data_to_send = 8'hFF;
                u_if.start        = 1'b1;
            end else if (c == inj_cyc + 1) begin
                u_if.start = 1'b0;
            end
            if (spi_sclk && !prev_s) begin
                o_rises++;
                if (o_first_rise < 0) o_first_rise = c;
            end
            if (!spi_sclk && prev_s) o_last_fall = c;
            prev_s = spi_sclk;
            if (c == 1)  o_busy1  = u_if.busy;
            if (c == 90) o_busy90 = u_if.busy;
            if (c == 91) o_busy91 = u_if.busy;
            if (u_if.done) begin
                o_done_cnt++;
                o_done_cyc     = c;
                o_rx           = u_if.data_received;
                o_cs_at_done   = spi_cs;
                o_busy_at_done = u_if.busy;
                if (stop_at_done) break;
            end
            if (!spi_cs) begin
                if (o_cs_first_low < 0) o_cs_first_low = c;
                o_cs_last_low = c;
            end else if (o_cs_first_low >= 0 && o_done_cnt == 0) begin
                o_cs_high_gap++;
            end
        end
    endtask

    int viol;

    initial begin
        u_if.start        = 1'b0;
        u_if.data_to_send = 8'h00;
        u_if.hold_cs      = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_cs",   spi_cs, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", u_if.busy, 0);
        chk("rst_done", u_if.done, 0);
        chk("rst_drx",  u_if.data_received, 8'h00);
        rst_n = 1'b1;

        // ---- idle behaviour ----
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spi_cs !== 1'b1 || spi_sclk !== 1'b0 || u_if.done !== 1'b0) viol++;
        end
        chk("idle_viol", viol, 0);

        // ---- single byte A5 / 3C ----
        sub_q.delete();
        sub_byte = 8'h3C;
        xfer(8'hA5, 1'b0, 95, 1'b0, -1);
        chk("sb_done_cyc",  o_done_cyc, 86);
        chk("sb_done_cnt",  o_done_cnt, 1);
        chk("sb_drx",       o_rx, 8'h3C);
        chk("sb_rises",     o_rises, 8);
        chk("sb_first_rise", o_first_rise, 6);
        chk("sb_last_fall", o_last_fall, 81);
        chk("sb_cs_first",  o_cs_first_low, 1);
        chk("sb_cs_last",   o_cs_last_low, 85);
        chk("sb_cs_at_done", o_cs_at_done, 1);
        chk("sb_busy1",     o_busy1, 1);
        chk("sb_busy90",    o_busy90, 1);
        chk("sb_busy91",    o_busy91, 0);
        chk("sb_sub_n",     sub_q.size(), 1);
        chk("sb_sub_rx",    sub_q[0], 8'hA5);

        // ---- multi-byte 0B,00,00 under held CS ----
        repeat (5) @(negedge clk);
        sub_q.delete();
        sub_byte = 8'h96;
        xfer(8'h0B, 1'b1, 200, 1'b1, -1);
        chk("mb1_done_cyc", o_done_cyc, 86);
        chk("mb1_drx",      o_rx, 8'h96);
        chk("mb1_cs_done",  o_cs_at_done, 0);
        chk("mb1_busy_done", o_busy_at_done, 0);
        chk("mb1_cs_gap",   o_cs_high_gap, 0);
        xfer(8'h00, 1'b1, 200, 1'b1, -1);
        chk("mb2_done_cyc", o_done_cyc, 86);
        chk("mb2_cs_done",  o_cs_at_done, 0);
        chk("mb2_cs_first", o_cs_first_low, 1);
        chk("mb2_cs_gap",   o_cs_high_gap, 0);
        xfer(8'h00, 1'b0, 200, 1'b1, -1);
        chk("mb3_done_cyc", o_done_cyc, 86);
        chk("mb3_cs_done",  o_cs_at_done, 1);
        chk("mb3_cs_first", o_cs_first_low, 1);
        chk("mb3_cs_gap",   o_cs_high_gap, 0);
        chk("mb_sub_n",     sub_q.size(), 3);
        chk("mb_sub0",      sub_q[0], 8'h0B);
        chk("mb_sub1",      sub_q[1], 8'h00);
        chk("mb_sub2",      sub_q[2], 8'h00);

        // ---- start while busy ----
        repeat (10) @(negedge clk);
        sub_q.delete();
        sub_byte = 8'h99;
        xfer(8'h42, 1'b0, 130, 1'b0, 20);
        chk("bz_done_cnt", o_done_cnt, 1);
        chk("bz_rises",    o_rises, 8);
        chk("bz_drx",      o_rx, 8'h99);
        chk("bz_sub_n",    sub_q.size(), 1);
        chk("bz_sub_rx",   sub_q[0], 8'h42);

        // ---- reset mid-transfer ----
        repeat (5) @(negedge clk);
        sub_byte = 8'h6E;
        u_if.data_to_send = 8'h77;
        u_if.hold_cs      = 1'b0;
        u_if.start        = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        repeat (40) @(negedge clk);
        chk("mr_pre_sclk", spi_sclk, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_cs",   spi_cs, 1);
        chk("mr_sclk", spi_sclk, 0);
        chk("mr_busy", u_if.busy, 0);
        chk("mr_drx",  u_if.data_received, 8'h00);
        viol = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (u_if.done !== 1'b0) viol++;
        end
        chk("mr_no_done", viol, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sub_q.delete();
        sub_byte = 8'hC3;
        xfer(8'h5A, 1'b0, 95, 1'b0, -1);
        chk("mr2_done_cyc", o_done_cyc, 86);
        chk("mr2_drx",      o_rx, 8'hC3);
        chk("mr2_sub_n",    sub_q.size(), 1);
        chk("mr2_sub_rx",   sub_q[0], 8'h5A);

        // ---- MISO pattern 81 (same timing with or without the synchronizer) ----
        repeat (5) @(negedge clk);
        sub_byte = 8'h81;
        xfer(8'hE7, 1'b0, 95, 1'b0, -1);
        chk("sy_done_cyc", o_done_cyc, 86);
        chk("sy_drx",      o_rx, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_cntrl.md
# spi_cntrl

SPI main-side controller sequencing single-byte and multi-byte transfers to one SPI subunit in mode 0 (CPOL=0, CPHA=0). It generates SPI_SCLK, SPI_CS and SPI_MOSI, and samples SPI_MISO. The user side is a start/busy/done handshake. It sits between user logic and any SPI peripheral, such as the ADXL362 accelerometer or the `spi_subunit` simulation model.

## Interface
- CLK_FREQUENCY, 100_000_000, system clock frequency in Hz.
- SCLK_FREQUENCY, 500_000, SPI_SCLK frequency in Hz.
  - HALF = CLK_FREQUENCY/(2*SCLK_FREQUENCY), integer division.
  - HALF ≥ 3 is required; a `$fatal` is raised at elaboration otherwise.

- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request a byte transfer; accepted only when busy=0
- data_to_send  input  8  byte to transmit, sampled in the start cycle, MSB first
- hold_cs  input  1  sampled with start; 1 keeps SPI_CS low after the byte
- data_received  output  8  last received byte, MSB first
- busy  output  1  transfer in progress; start is ignored
- done  output  1  one-cycle pulse when data_received is updated
- SPI_SCLK  output  1  serial clock, idle low
- SPI_MOSI  output  1  serial data out
- SPI_MISO  input  1  serial data in, tri-stated by the subunit when CS is high
- SPI_CS  output  1  chip select, active-low

## Operation
- States: IDLE, LOW, HIGH, CS_HOLD, HOLD, GAP.
- Reset (rst_n=0, immediate): state=IDLE.
  - SPI_CS=1, SPI_SCLK=0, SPI_MOSI=0, busy=0, done=0, data_received=8'h00.
  - All counters are cleared.
- IDLE or HOLD with start=1:
  - Latch data_to_send into the shift register and latch hold_cs.
  - Go to LOW with the bit counter at 0; busy=1 from the next cycle.
- LOW: SPI_CS=0, SPI_SCLK=0, SPI_MOSI=shift[7].
  - After HALF cycles, go to HIGH.
- HIGH, entry cycle (SCLK rising edge): SPI_MISO is shifted into rx[0].
  - After HALF cycles:
    - bit counter < 7: shift tx left, increment the counter, go to LOW (falling edge; MOSI updates in that same cycle).
    - bit counter = 7: go to CS_HOLD.
- CS_HOLD: SPI_SCLK=0, SPI_CS=0 for HALF cycles. On exit:
  - done=1 for one cycle and data_received=rx.
  - Latched hold_cs=1: go to HOLD (busy=0, SPI_CS stays 0).
  - Latched hold_cs=0: SPI_CS=1 in the same cycle, go to GAP.
- HOLD: SPI_CS=0, SPI_SCLK=0, busy=0. Waits for the next start; there is no timeout.
  - To release CS, issue a final byte with hold_cs=0.
- GAP: SPI_CS=1, busy=1 for HALF cycles, then go to IDLE.
- start while busy=1 is ignored; no queueing.
- Reset mid-transfer: SPI_CS=1 and SPI_SCLK=0 immediately; no done pulse; the partial rx byte is discarded.
- Exactly 8 SCLK rising edges occur per byte.

## Timing
- Cycle 0 is the start-accept edge.
  - SPI_CS falls at cycle 1.
  - SCLK rises at cycles 1+HALF+2k·HALF, for k=0..7.
  - Last SCLK fall is at cycle 1+16·HALF.
  - done is high at cycle 1+17·HALF.
- Minimum CS-low setup and hold around SCLK edges: HALF cycles each.
- Minimum CS-high time between transfers: HALF cycles.
- done and the data_received update are coincident.
  - data_received is stable until the next done.
- In HOLD, a start issued in the same cycle as done's successor is accepted.
  - Back-to-back bytes under CS are separated by HALF cycles of CS_HOLD plus one cycle.

## Configuration
- SPI_CNTRL_MISO_SYNC_EN defined:
  - SPI_MISO passes through a 2-flop synchronizer, reset to 0, before sampling.
  - The sample point is still the HIGH entry cycle.
  - Correct because MISO is stable for the whole preceding low phase, HALF ≥ 3 cycles.
- Not defined: SPI_MISO is sampled directly.
- Cycle timing of all outputs is identical either way.

## Test plan
Bench setup for all scenarios: CLK_FREQUENCY=100 MHz, SCLK_FREQUENCY=10 MHz (HALF=5), paired with a mode-0 subunit model.

- Single byte: start, data_to_send=8'hA5, hold_cs=0, subunit sends 8'h3C.
  - Subunit receives 8'hA5; data_received=8'h3C.
  - done at cycle 86; exactly 8 SCLK rising edges; SPI_CS low for cycles 1–85.
- Multi-byte: bytes 8'h0B, 8'h00, 8'h00, with hold_cs=1,1,0.
  - SPI_CS never rises between bytes; three done pulses.
  - Subunit receives 8'h0B, 8'h00, 8'h00.
  - SPI_CS rises in the third done cycle.
- Start while busy: second start with 8'hFF at cycle 20 of a transfer.
  - Ignored; only the first byte appears on MOSI; one done pulse.
- Reset mid-transfer: rst_n low at cycle 40.
  - Same cycle: SPI_CS=1, SPI_SCLK=0, busy=0, data_received=8'h00; no done.
  - After release, a new 8'h5A transfer completes correctly.
- Sync build: with SPI_CNTRL_MISO_SYNC_EN defined, repeat the single-byte test with subunit sending 8'h81.
  - data_received=8'h81, done at cycle 86.
- Idle behaviour: for 200 cycles with no start, SPI_CS=1, SPI_SCLK=0 and done=0 throughout.
